// File: rtl/syn_global_pkg.sv
// Shared SRAM bus constants and types for the VCORTEX SRAM path.
// Owner tags identify which requester issued an outstanding read.
package syn_global_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic {
        ARB_OWNER_GPU = 1'b0,
        ARB_OWNER_VGA = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/syn_sram_arb_tag_fifo.sv
// Owner-tag FIFO: remembers who issued each outstanding SRAM read,
// popped in issue order as read data comes back.
module syn_sram_arb_tag_fifo
    import syn_global_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  arb_owner_t    i_owner,
    input  logic          i_pop,
    output arb_owner_t    o_owner,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    arb_owner_t    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    assign o_owner = r_mem[r_rp];
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= ARB_OWNER_GPU;
            end
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_owner;
                r_wp        <= r_wp + AW'(1);
            end
            if (i_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            unique case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/syn_sram_acc_arb.sv
// VGA/GPU arbiter for the SRAM memory driver: VGA has priority,
// GPU gets a forced slot after a VGA burst, reads routed back by tag.
module syn_sram_acc_arb
    import syn_global_pkg::*;
#(
    parameter int ADDR_W        = SRAM_ADDR_W,
    parameter int DATA_W        = SRAM_DATA_W,
    parameter int RD_TAG_DEPTH  = 4,
    parameter int VGA_BURST_MAX = 8
)(
    input  logic              clk_ir,
    input  logic              rst_sync_l,
    input  logic              vga_rd_en,
    input  logic              vga_wr_en,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic [DATA_W-1:0] vga_wr_data,
    output logic              vga_ready,
    output logic              vga_rd_valid,
    output logic [DATA_W-1:0] vga_rd_data,
    input  logic              gpu_rd_en,
    input  logic              gpu_wr_en,
    input  logic [ADDR_W-1:0] gpu_addr,
    input  logic [DATA_W-1:0] gpu_wr_data,
    output logic              gpu_ready,
    output logic              gpu_rd_valid,
    output logic [DATA_W-1:0] gpu_rd_data,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_ready,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              tag_underflow_err,
    output logic              req_conflict_err
);

    localparam int BW = $clog2(VGA_BURST_MAX + 1);
    localparam int CW = $clog2(RD_TAG_DEPTH) + 1;

    logic [BW-1:0] r_burst;
    logic          r_vga_v;
    logic          r_gpu_v;
    logic [DATA_W-1:0] r_rd_data;
    logic          r_udf;
    logic          r_cnf;

    logic          w_vga_pend;
    logic          w_gpu_pend;
    logic          w_vga_rd;
    logic          w_gpu_rd;
    logic          w_burst_max;
    logic          w_gnt_vga;
    logic          w_gnt_gpu;
    logic          w_vga_xfer;
    logic          w_gpu_xfer;
    logic          w_tag_full;
    logic          w_tag_empty;
    logic [CW-1:0] w_tag_cnt;
    arb_owner_t    w_tag_out;
    arb_owner_t    w_owner;
    logic          w_pop;
    logic          w_conflict;

    // A write beats a simultaneous read on the same requester.
    assign w_vga_pend = vga_rd_en | vga_wr_en;
    assign w_gpu_pend = gpu_rd_en | gpu_wr_en;
    assign w_vga_rd   = vga_rd_en & ~vga_wr_en;
    assign w_gpu_rd   = gpu_rd_en & ~gpu_wr_en;
    assign w_conflict = (vga_rd_en & vga_wr_en)
                      | (gpu_rd_en & gpu_wr_en);

    assign w_burst_max = (r_burst == BW'(VGA_BURST_MAX));

    // Held in reset, nobody is granted so every command output is 0.
    assign w_gnt_gpu = rst_sync_l & w_gpu_pend
                     & (~w_vga_pend | w_burst_max);
    assign w_gnt_vga = rst_sync_l & w_vga_pend & ~w_gnt_gpu;

    // A full tag FIFO stalls only the granted read; no grant handover.
    assign vga_ready = w_gnt_vga & mem_ready
                     & ~(w_vga_rd & w_tag_full);
    assign gpu_ready = w_gnt_gpu & mem_ready
                     & ~(w_gpu_rd & w_tag_full);

    assign w_vga_xfer = w_vga_pend & vga_ready;
    assign w_gpu_xfer = w_gpu_pend & gpu_ready;

    assign mem_rd_en = (w_vga_xfer & w_vga_rd)
                     | (w_gpu_xfer & w_gpu_rd);
    assign mem_wr_en = (w_vga_xfer & vga_wr_en)
                     | (w_gpu_xfer & gpu_wr_en);

    assign w_owner = w_gnt_vga ? ARB_OWNER_VGA : ARB_OWNER_GPU;
    assign w_pop   = mem_rd_valid & ~w_tag_empty;

    // Address/data follow the granted requester with no added latency.
    always_comb begin
        mem_addr    = '0;
        mem_wr_data = '0;
        if (w_gnt_vga) begin
            mem_addr    = vga_addr;
            mem_wr_data = vga_wr_data;
        end else if (w_gnt_gpu) begin
            mem_addr    = gpu_addr;
            mem_wr_data = gpu_wr_data;
        end
    end

    syn_sram_arb_tag_fifo #(
        .DEPTH (RD_TAG_DEPTH),
        .CW    (CW)
    ) u_tag_fifo (
        .clk     (clk_ir),
        .rst_n   (rst_sync_l),
        .i_push  (mem_rd_en),
        .i_owner (w_owner),
        .i_pop   (w_pop),
        .o_owner (w_tag_out),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty),
        .o_count (w_tag_cnt)
    );

    // Count VGA wins while GPU waits; reset when GPU is served or idle.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            r_burst <= '0;
        end else if (!w_gpu_pend || w_gpu_xfer) begin
            r_burst <= '0;
        end else if (w_vga_xfer && !w_burst_max) begin
            r_burst <= r_burst + BW'(1);
        end
    end

    // Registered read return, steered by the oldest owner tag.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            r_vga_v   <= 1'b0;
            r_gpu_v   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_vga_v <= w_pop & (w_tag_out == ARB_OWNER_VGA);
            r_gpu_v <= w_pop & (w_tag_out == ARB_OWNER_GPU);
            if (mem_rd_valid) begin
                r_rd_data <= mem_rd_data;
            end
        end
    end

    // Sticky protocol error flags.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            r_udf <= 1'b0;
            r_cnf <= 1'b0;
        end else begin
            if (mem_rd_valid && w_tag_cnt == '0) begin
                r_udf <= 1'b1;
            end
            if (w_conflict) begin
                r_cnf <= 1'b1;
            end
        end
    end

    assign vga_rd_valid      = r_vga_v;
    assign gpu_rd_valid      = r_gpu_v;
    assign vga_rd_data       = r_rd_data;
    assign gpu_rd_data       = r_rd_data;
    assign tag_underflow_err = r_udf;
    assign req_conflict_err  = r_cnf;

endmodule
